uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, payload bits per frame; legal range 4..9.
REQ-002 SHALL provide parameter CLKS_PER_BIT, default 4, clk cycles per serial bit; legal range >= 1.
REQ-003 SHALL provide parameter PARITY_EN, default 0, 1 inserts one parity bit after the data bits.
REQ-004 SHALL provide parameter PARITY_ODD, default 0, 0 selects even parity and 1 selects odd parity; ignored when PARITY_EN=0.
REQ-005 SHALL provide parameter STOP_BITS, default 1, number of stop bits; legal values 1 and 2.
REQ-006 SHALL provide port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL provide port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-008 SHALL provide port tx_ena, input, 1 bit, request to send tx_data.
REQ-009 SHALL provide port tx_data, input, DATA_W bits, payload; sampled only on acceptance.
REQ-010 SHALL provide port tx, output, 1 bit, serial line; idle level 1.
REQ-011 SHALL provide port tx_busy, output, 1 bit, high while a frame is in progress.
REQ-012 SHALL provide port tx_done, output, 1 bit, one-cycle pulse at frame completion.

Function
REQ-013 SHALL use states IDLE, START, DATA, PARITY, STOP; the line frame is start(0), data LSB first, optional parity, STOP_BITS stop bits (1).
REQ-014 SHALL accept a request only when state=IDLE and tx_ena=1 at a rising edge; on that edge: latch tx_data, set tx_busy=1, enter START, drive tx=0.
REQ-015 SHALL ignore tx_ena while tx_busy=1; the latched payload SHALL NOT change mid-frame.
REQ-016 SHALL hold each serial bit on tx for exactly CLKS_PER_BIT cycles, timed by a baud counter of width max(1,clog2(CLKS_PER_BIT)) that resets at every bit boundary.
REQ-017 SHALL run START -> DATA (DATA_W bits, index counter 0..DATA_W-1) -> PARITY (if PARITY_EN) -> STOP (STOP_BITS bits) -> IDLE.
REQ-018 SHALL compute the parity bit as the XOR reduction of the latched data for even parity, and its inverse for odd parity.
REQ-019 SHALL make the frame length (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, measured from the acceptance edge to the return-to-IDLE edge.
REQ-020 SHALL, on the edge that ends the last stop bit, enter IDLE, set tx_busy=0 and pulse tx_done=1 for exactly one cycle; tx stays 1.
REQ-021 SHALL allow back-to-back frames: with tx_ena=1 during the tx_done cycle, the next edge accepts the new frame, giving no extra idle bit time.
REQ-022 SHALL register tx; it SHALL be glitch-free and SHALL never be X after reset.
REQ-023 SHALL handle CLKS_PER_BIT=1 so that each bit lasts exactly one cycle.

Reset
REQ-024 SHALL, while rst=1 (asynchronous, immediately), force state=IDLE, tx=1, tx_busy=0, tx_done=0, and all counters and the data register to 0.
REQ-025 SHALL abort a frame in progress when rst asserts mid-frame; no tx_done SHALL pulse for that frame, and after release the first accepted request starts a fresh frame.

Verification
REQ-026 SHALL cover: defaults, tx_data=0xA5 accepted -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_busy high 40 cycles; tx_done pulses once at cycle 40.
REQ-027 SHALL cover: PARITY_EN=1, PARITY_ODD=0, tx_data=0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame length 44 cycles.
REQ-028 SHALL cover: STOP_BITS=2, DATA_W=5, CLKS_PER_BIT=1, tx_data=0x15 -> tx = 0,1,0,1,0,1,1,1; busy 8 cycles.
REQ-029 SHALL cover: tx_ena pulsed with 0x3C at cycle 10 of a 0xA5 frame -> ignored; the line shows only 0xA5; exactly one tx_done.
REQ-030 SHALL cover: rst asserted at cycle 17 of a frame -> tx=1 and tx_busy=0 immediately, no tx_done; the next request after release produces a clean frame.
REQ-031 SHALL cover: tx_ena held high for two frames (0x01 then 0x80) -> frames abut exactly; the second start bit begins on the cycle after the first tx_done.

Source files
------------

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterized UART transmitter.
// Frame: start(0), DATA_W data bits LSB first, optional parity, STOP_BITS stop(1).
// Each line bit is held for CLKS_PER_BIT clk cycles.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   tx_ena   - send request, accepted only while idle
//   tx_data  - payload, latched on acceptance
//   tx       - registered serial line, idles high
//   tx_busy  - high while a frame is in progress
//   tx_done  - one-cycle pulse on the edge that returns to idle
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_ena,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic          PAR_ON    = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              bit_end;
  logic [IW-1:0]     nxt_idx;
  logic [DATA_W-1:0] data_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are computed one cycle ahead so tx/busy/done come straight off flops.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bit_end = (baud_q == BAUD_LAST);
    nxt_idx = idx_q + 1'b1;
    data_sh = data_q >> nxt_idx;

    if (state_q == IDLE) begin
      tx_d   = 1'b1;
      busy_d = 1'b0;
      if (tx_ena) begin
        data_d  = tx_data;
        state_d = START;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
        baud_d  = '0;
        idx_d   = '0;
      end
    end else if (!bit_end) begin
      baud_d = baud_q + 1'b1;
    end else begin
      baud_d = '0;
      case (state_q)
        START: begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
        DATA: begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (PAR_ON) begin
              state_d = PARITY;
              tx_d    = (^data_q) ^ ODD;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = nxt_idx;
            tx_d  = data_sh[0];
          end
        end
        PARITY: begin
          state_d = STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
        STOP: begin
          tx_d = 1'b1;
          if (idx_q == STOP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = nxt_idx;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four instances with different
// parameter sets; stimulus pushes hand-written line sequences, a negedge
// monitor decodes each frame cycle by cycle and compares.
module tb_uart_tx_param;

  typedef struct {
    int          d;
    logic [0:15] seq;   // wire order, left to right
    int          n;
    int          cpb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ena_v = '0;
  logic [7:0] data_v [3];
  logic [4:0] data3 = '0;
  logic [3:0] tx_v, busy_v, done_v;

  int compared = 0;
  int errs = 0;
  int cyc = 0;
  int aborted = 0;

  exp_t sbq[$];
  exp_t cur [4];
  bit   act [4];
  bit   ign [4];
  bit   chk_done [4];
  bit   bad [4];
  int   k [4];
  int   badk [4];
  logic badv [4];
  int   busycnt [4];
  int   frames [4];
  int   done_cyc [4];
  int   gap [4];

  always #5 clk = ~clk;

  uart_tx_param u0 (.clk(clk), .rst(rst), .tx_ena(ena_v[0]), .tx_data(data_v[0]),
                    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .tx_ena(ena_v[1]), .tx_data(data_v[1]),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx_param #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .tx_ena(ena_v[2]), .tx_data(data_v[2]),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_ena(ena_v[3]), .tx_data(data3),
    .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  // Monitor
  always @(negedge clk) begin
    logic eb;
    cyc++;
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        if (act[d]) aborted++;
        act[d] = 0; chk_done[d] = 0; ign[d] = 0;
      end else begin
        if (chk_done[d]) begin
          compared++;
          if (done_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || tx_v[d] !== 1'b1) begin
            errs++;
            $display("FAIL done_pulse dut%0d: done=%b busy=%b tx=%b, want 1 0 1",
                     d, done_v[d], busy_v[d], tx_v[d]);
          end
          done_cyc[d] = cyc; chk_done[d] = 0;
        end else if (done_v[d] !== 1'b0) begin
          compared++; errs++;
          $display("FAIL spurious_done dut%0d cyc %0d: done=%b want 0", d, cyc, done_v[d]);
        end
        if (ign[d]) begin
          if (busy_v[d] === 1'b0 && tx_v[d] === 1'b1) ign[d] = 0;
        end else if (!act[d] && tx_v[d] === 1'b0) begin
          if (sbq.size() == 0 || sbq[0].d != d) begin
            compared++; errs++; ign[d] = 1;
            $display("FAIL unexpected_frame dut%0d cyc %0d: start bit seen, none queued", d, cyc);
          end else begin
            cur[d] = sbq.pop_front();
            act[d] = 1; k[d] = 0; bad[d] = 0; busycnt[d] = 0;
            gap[d] = cyc - done_cyc[d];
          end
        end
        if (act[d]) begin
          eb = cur[d].seq[k[d] / cur[d].cpb];
          if (tx_v[d] !== eb && !bad[d]) begin
            bad[d] = 1; badk[d] = k[d]; badv[d] = tx_v[d];
          end
          if (busy_v[d] === 1'b1) busycnt[d]++;
          k[d]++;
          if (k[d] == cur[d].n * cur[d].cpb) begin
            compared += 2;
            if (bad[d]) begin
              errs++;
              $display("FAIL line_bits dut%0d: cycle %0d of frame got tx=%b, want %b",
                       d, badk[d], badv[d], cur[d].seq[badk[d] / cur[d].cpb]);
            end
            if (busycnt[d] != k[d]) begin
              errs++;
              $display("FAIL busy_len dut%0d: busy %0d cycles, want %0d", d, busycnt[d], k[d]);
            end
            act[d] = 0; chk_done[d] = 1; frames[d]++;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic send(input int d, input logic [7:0] v, input logic [0:15] seq,
                      input int n, input int cpb);
    exp_t e;
    e.d = d; e.seq = seq; e.n = n; e.cpb = cpb;
    sbq.push_back(e);
    @(posedge clk); #1;
    ena_v[d] = 1'b1;
    if (d == 3) data3 = v[4:0]; else data_v[d] = v;
    @(posedge clk); #1;   // accepted on this edge
    ena_v[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while ((act[d] || chk_done[d] || ign[d] || sbq.size() != 0) && n < 300) begin
      @(posedge clk); n++;
    end
    if (n >= 300) begin
      compared++; errs++;
      $display("FAIL timeout dut%0d: frame not finished in 300 cycles", d);
      sbq.delete();
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int f0, n;
    for (int i = 0; i < 3; i++) data_v[i] = '0;
    for (int i = 0; i < 4; i++) begin
      act[i] = 0; ign[i] = 0; chk_done[i] = 0; frames[i] = 0; done_cyc[i] = -100; gap[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx",   int'(tx_v),   4'hF);
    check("reset_busy", int'(busy_v), 0);
    check("reset_done", int'(done_v), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // defaults, 0xA5
    send(0, 8'hA5, 16'b0101001011000000, 10, 4);
    wait_idle(0);
    check("frames_a5", frames[0], 1);
    // even / odd parity, 0x07
    send(1, 8'h07, 16'b0111000001100000, 11, 4);
    wait_idle(1);
    send(2, 8'h07, 16'b0111000000100000, 11, 4);
    wait_idle(2);
    // DATA_W=5, CPB=1, two stop bits, 0x15
    send(3, 8'h15, 16'b0101011100000000, 8, 1);
    wait_idle(3);
    check("frames_par_s2", frames[1] + frames[2] + frames[3], 3);

    // request mid-frame is ignored
    f0 = frames[0];
    send(0, 8'hA5, 16'b0101001011000000, 10, 4);
    repeat (9) @(posedge clk);
    #1; ena_v[0] = 1'b1; data_v[0] = 8'h3C;
    @(posedge clk); #1; ena_v[0] = 1'b0;
    wait_idle(0);
    check("ignore_frames", frames[0] - f0, 1);

    // reset mid-frame
    f0 = frames[0];
    send(0, 8'hA5, 16'b0101001011000000, 10, 4);
    repeat (16) @(posedge clk);
    #2; rst = 1'b1;
    #1;
    check("rst_tx",   int'(tx_v[0]),   1);
    check("rst_busy", int'(busy_v[0]), 0);
    check("rst_done", int'(done_v[0]), 0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    check("aborted", aborted, 1);
    check("no_done_after_abort", frames[0] - f0, 0);
    send(0, 8'h5A, 16'b0010110101000000, 10, 4);
    wait_idle(0);
    check("frame_after_rst", frames[0] - f0, 1);

    // back-to-back with tx_ena held
    begin
      exp_t e;
      e.d = 0; e.n = 10; e.cpb = 4;
      e.seq = 16'b0100000001000000; sbq.push_back(e);
      e.seq = 16'b0000000011000000; sbq.push_back(e);
    end
    f0 = frames[0];
    @(posedge clk); #1;
    ena_v[0] = 1'b1; data_v[0] = 8'h01;
    @(posedge clk); #1;
    data_v[0] = 8'h80;
    n = 0;
    while (done_v[0] !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("b2b_done_seen", int'(n < 200), 1);
    @(posedge clk); #1;
    ena_v[0] = 1'b0;
    wait_idle(0);
    check("b2b_frames", frames[0] - f0, 2);
    check("b2b_gap", gap[0], 1);

    check("queue_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
